// File: rtl/packet_link_arbiter_if.sv
// Requester-buffer and link-side signals of packet_link_arbiter, grouped as one bundle.
// master = the arbiter; slave = the requester buffers plus the link receiver.
interface packet_link_arbiter_if #(
  parameter int PK_W  = 32,
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_empty;
  logic [N_REQ*PK_W-1:0] req_data;
  logic [N_REQ-1:0]      req_pop;
  logic [PK_W-1:0]       packet_out;
  logic                  tick;
  logic                  read_req;
  logic [ID_W-1:0]       grant_id;
  logic                  link_busy;
  logic                  timeout_err;

  modport master (
    input  req_empty, req_data, read_req,
    output req_pop, packet_out, tick, grant_id, link_busy, timeout_err
  );

  modport slave (
    output req_empty, req_data, read_req,
    input  req_pop, packet_out, tick, grant_id, link_busy, timeout_err
  );
endinterface

// File: rtl/packet_link_arbiter.sv
// Round-robin arbiter sharing one packet link among N_REQ FWFT requester buffers.
// Optional macro LINK_TIMEOUT_EN adds a WAIT-state timeout that drops the word and pulses timeout_err.
//
// state  | meaning
// S_IDLE | searching from rr_ptr for a non-empty buffer; pops and latches the winner
// S_SEND | tick strobe for the latched word
// S_WAIT | holding packet_out until the receiver's read_req (or a timeout)
module packet_link_arbiter #(
  parameter int PK_W        = 32,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                    clk,
  input logic                    rst,
  packet_link_arbiter_if.master  bus
);
  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("packet_link_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PK_W-1:0]   r_packet_out;
  logic [ID_W-1:0]   r_grant_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_next_ptr;
  logic [PK_W-1:0]   w_win_data;
  logic              w_found;
  logic              w_load;
  logic              w_done;
  logic              w_timeout;

  always_comb begin
    int v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && !bus.req_empty[v_idx]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(v_idx);
      end
    end
  end

  assign w_win_data = bus.req_data[int'(w_winner)*PK_W +: PK_W];
  assign w_next_ptr = (r_grant_id == ID_W'(N_REQ-1)) ? '0 : r_grant_id + 1'b1;

`ifdef LINK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Down-counter loaded while in SEND so it reads TIMEOUT_CYC on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_SEND) begin
      r_to_cnt <= TO_W'(TIMEOUT_CYC);
    end else if (r_state == S_WAIT && !bus.read_req && r_to_cnt != '0) begin
      r_to_cnt <= r_to_cnt - 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !bus.read_req && (r_to_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.read_req || w_timeout) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_packet_out <= '0;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_packet_out <= w_win_data;
        r_grant_id   <= w_winner;
      end
      if (w_done) r_rr_ptr <= w_next_ptr;
    end
  end

  // Pop is combinational; rst gating keeps it low while reset holds the FSM in IDLE.
  assign bus.req_pop     = (w_load && rst) ? (N_REQ'(1) << w_winner) : '0;
  assign bus.packet_out  = r_packet_out;
  assign bus.grant_id    = r_grant_id;
  assign bus.tick        = (r_state == S_SEND);
  assign bus.link_busy   = (r_state != S_IDLE);
  assign bus.timeout_err = w_timeout;
endmodule
